// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module   : fifo_uart_tx
// Brief    : Pops bytes from a 1-cycle-latency FIFO and serialises them as
//            UART frames (start, 8 data LSB first, optional parity, stop).
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_en,
    input  logic [7:0]  fifo_data,
    input  logic        fifo_empty,
    output logic        rd_en,
    output logic        tx,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_FETCH  = 3'd1;
    localparam logic [2:0] c_S_LATCH  = 3'd2;
    localparam logic [2:0] c_S_START  = 3'd3;
    localparam logic [2:0] c_S_DATA   = 3'd4;
    localparam logic [2:0] c_S_PARITY = 3'd5;
    localparam logic [2:0] c_S_STOP   = 3'd6;

    localparam logic [15:0] c_BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [15:0] r_baud;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_par;
    logic        r_tx;
    logic        w_tx_nxt;
    logic [15:0] r_frame_cnt;
    logic        w_bit_done;
    logic        w_can_start;

    assign w_bit_done  = (r_baud == c_BAUD_MAX);
    assign w_can_start = tx_en && !fifo_empty;

    // State register plus the datapath that advances with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_S_IDLE;
            r_tx        <= 1'b1;
            r_baud      <= 16'd0;
            r_bit       <= 3'd0;
            r_shift     <= 8'd0;
            r_par       <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            case (r_state)
                c_S_LATCH: begin
                    r_shift <= fifo_data;
                    r_par   <= (^fifo_data) ^ (PARITY_ODD != 0);
                    r_baud  <= 16'd0;
                    r_bit   <= 3'd0;
                end
                c_S_START, c_S_DATA, c_S_PARITY, c_S_STOP: begin
                    if (w_bit_done) begin
                        r_baud <= 16'd0;
                        if (r_state == c_S_DATA) begin
                            r_shift <= r_shift >> 1;
                            r_bit   <= r_bit + 3'd1;
                        end
                        if (r_state == c_S_STOP) begin
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: r_baud <= 16'd0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:   if (w_can_start) w_state_nxt = c_S_FETCH;
            c_S_FETCH:  w_state_nxt = c_S_LATCH;
            c_S_LATCH:  w_state_nxt = c_S_START;
            c_S_START:  if (w_bit_done) w_state_nxt = c_S_DATA;
            c_S_DATA: begin
                if (w_bit_done && (r_bit == 3'd7)) begin
                    w_state_nxt = (PARITY_EN != 0) ? c_S_PARITY : c_S_STOP;
                end
            end
            c_S_PARITY: if (w_bit_done) w_state_nxt = c_S_STOP;
            c_S_STOP: begin
                if (w_bit_done) begin
                    w_state_nxt = w_can_start ? c_S_FETCH : c_S_IDLE;
                end
            end
            default:    w_state_nxt = c_S_IDLE;
        endcase
    end

    // Line level is chosen from the state being entered so tx stays registered
    always_comb begin
        rd_en    = (r_state == c_S_FETCH);
        busy     = (r_state != c_S_IDLE);
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            c_S_START:  w_tx_nxt = 1'b0;
            c_S_DATA: begin
                if ((r_state == c_S_DATA) && w_bit_done) begin
                    w_tx_nxt = r_shift[1];
                end else begin
                    w_tx_nxt = r_shift[0];
                end
            end
            c_S_PARITY: w_tx_nxt = r_par;
            default:    w_tx_nxt = 1'b1;
        endcase
    end

    assign tx        = r_tx;
    assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// ============================================================================
// Module   : tb_fifo_uart_tx
// Brief    : Self-checking bench: three instances (no parity / even / odd),
//            each fed by a small 1-cycle-latency FIFO model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_uart_tx;

    localparam int CPB = 4;

    typedef struct {
        int          k;
        logic [7:0]  b;
        logic        p;
        logic [15:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  tx_en;
    logic [2:0]  fifo_empty;
    logic [2:0]  rd_en;
    logic [2:0]  tx;
    logic [2:0]  busy;
    logic [7:0]  fifo_data [3];
    logic [15:0] frame_cnt [3];

    logic [7:0]  mem [3][32];
    int          wp [3] = '{0, 0, 0};
    int          rp [3] = '{0, 0, 0};

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign fifo_empty[g] = (wp[g] == rp[g]);
        fifo_uart_tx #(
            .CLKS_PER_BIT (CPB),
            .PARITY_EN    ((g != 0) ? 1 : 0),
            .PARITY_ODD   ((g == 2) ? 1 : 0)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .tx_en      (tx_en[g]),
            .fifo_data  (fifo_data[g]),
            .fifo_empty (fifo_empty[g]),
            .rd_en      (rd_en[g]),
            .tx         (tx[g]),
            .busy       (busy[g]),
            .frame_cnt  (frame_cnt[g])
        );
    end

    // FIFO models: data appears the cycle after the pop strobe
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rd_en[k] === 1'b1) begin
                fifo_data[k] <= mem[k][rp[k] % 32];
                rp[k]        <= rp[k] + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] b);
        mem[k][wp[k] % 32] = b;
        wp[k] = wp[k] + 1;
    endtask

    // Waits for the start bit, checks idle-high length before it, then the
    // full frame waveform cycle by cycle.
    task automatic rx_check(input int k, input logic [7:0] b, input logic p,
                            input int exp_gap, input string nm);
        int n;
        int nb;
        int bad;
        logic [10:0] line;
        n = 0;
        while (tx[k] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk({nm, "_timeout"}, 32'(n), 32'(exp_gap));
            return;
        end
        chk({nm, "_gap"}, 32'(n), 32'(exp_gap));
        line      = '1;
        line[0]   = 1'b0;
        line[8:1] = b;
        if (k != 0) line[9] = p;
        nb  = (k == 0) ? 10 : 11;
        bad = 0;
        for (int i = 0; i < nb * CPB; i++) begin
            if (tx[k] !== line[i / CPB]) bad++;
            @(negedge clk);
        end
        chk({nm, "_wave_errs"}, 32'(bad), 32'd0);
    endtask

    vec_t vt [6];

    initial begin
        int bad;
        int rp0;
        int n;

        vt[0] = '{k: 0, b: 8'h00, p: 1'b0, cnt: 16'd2};
        vt[1] = '{k: 0, b: 8'hFF, p: 1'b0, cnt: 16'd3};
        vt[2] = '{k: 1, b: 8'h07, p: 1'b1, cnt: 16'd1};
        vt[3] = '{k: 1, b: 8'h03, p: 1'b0, cnt: 16'd2};
        vt[4] = '{k: 2, b: 8'h07, p: 1'b0, cnt: 16'd1};
        vt[5] = '{k: 2, b: 8'h03, p: 1'b1, cnt: 16'd2};

        rst   = 1'b0;
        tx_en = 3'b111;
        push(0, 8'hA5);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (tx[k] !== 1'b1 || rd_en[k] !== 1'b0 || busy[k] !== 1'b0 ||
                    frame_cnt[k] !== 16'd0) bad++;
            end
        end
        chk("reset_hold_errs", 32'(bad), 32'd0);
        chk("reset_tx", 32'(tx[0]), 32'd1);
        chk("reset_frame_cnt", 32'(frame_cnt[0]), 32'd0);
        chk("reset_no_pop", 32'(rp[0]), 32'd0);

        // Byte queued during reset goes out once reset is released
        rst = 1'b1;
        rx_check(0, 8'hA5, 1'b0, 3, "a5");
        chk("a5_cnt", 32'(frame_cnt[0]), 32'd1);
        chk("a5_pops", 32'(rp[0]), 32'd1);
        chk("a5_busy", 32'(busy[0]), 32'd0);

        for (int i = 0; i < 6; i++) begin
            push(vt[i].k, vt[i].b);
            rx_check(vt[i].k, vt[i].b, vt[i].p, 3, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_cnt", i), 32'(frame_cnt[vt[i].k]), 32'(vt[i].cnt));
            chk($sformatf("vec%0d_busy", i), 32'(busy[vt[i].k]), 32'd0);
        end

        // Back-to-back streaming from a fresh reset
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rp0 = rp[0];
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        rx_check(0, 8'h11, 1'b0, 3, "s0");
        rx_check(0, 8'h22, 1'b0, 2, "s1");
        rx_check(0, 8'h33, 1'b0, 2, "s2");
        chk("stream_cnt", 32'(frame_cnt[0]), 32'd3);
        chk("stream_pops", 32'(rp[0] - rp0), 32'd3);
        chk("stream_busy", 32'(busy[0]), 32'd0);
        chk("stream_empty", 32'(fifo_empty[0]), 32'd1);

        // tx_en dropped mid-frame with two bytes still queued
        rp0 = rp[1];
        push(1, 8'h5A);
        push(1, 8'h01);
        push(1, 8'h3C);
        repeat (10) @(negedge clk);
        tx_en[1] = 1'b0;
        n = 0;
        while (busy[1] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("txen_cnt", 32'(frame_cnt[1]), 32'd1);
        repeat (20) @(negedge clk);
        chk("txen_idle_busy", 32'(busy[1]), 32'd0);
        chk("txen_pops", 32'(rp[1] - rp0), 32'd1);
        chk("txen_fifo_level", 32'(wp[1] - rp[1]), 32'd2);
        tx_en[1] = 1'b1;
        rx_check(1, 8'h01, 1'b1, 3, "txen_r0");
        rx_check(1, 8'h3C, 1'b0, 2, "txen_r1");
        chk("txen_cnt_end", 32'(frame_cnt[1]), 32'd3);

        // Reset in the middle of D1 of 0xC1 drops that byte
        push(2, 8'h07);
        rx_check(2, 8'h07, 1'b0, 3, "pre");
        chk("pre_cnt", 32'(frame_cnt[2]), 32'd1);
        rp0 = rp[2];
        push(2, 8'hC1);
        push(2, 8'h5E);
        n = 0;
        while (tx[2] !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (9) @(negedge clk);
        chk("mid_tx_low", 32'(tx[2]), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx[2]), 32'd1);
        chk("mid_rst_busy", 32'(busy[2]), 32'd0);
        chk("mid_rst_rd_en", 32'(rd_en[2]), 32'd0);
        @(negedge clk);
        chk("mid_rst_cnt", 32'(frame_cnt[2]), 32'd0);
        rst = 1'b1;
        rx_check(2, 8'h5E, 1'b0, 3, "post");
        chk("post_cnt", 32'(frame_cnt[2]), 32'd1);
        chk("post_pops", 32'(rp[2] - rp0), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire
